// File: rtl/udp_tx_pkg.sv
// Shared types and constants for the UDP TX framer slice.
package udp_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        DROP,
        SEND,
        WAIT_ACK
    } udp_tx_state_t;

    localparam int         UDP_WORD_BYTES = 8;
    localparam logic [7:0] UDP_DV_FULL    = 8'hFF;

    // Saturating increment for the 32-bit statistics counters
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/udp_tx_framer_if.sv
// Stream-in / UDP-TX-out signal bundle of the framer.
// slave  : the framer side (consumes the stream, drives the UDP client TX port)
// master : the packet source / UDP core side
interface udp_tx_framer_if;

    logic [udp_tx_pkg::UDP_WORD_BYTES*8-1:0] s_tdata;
    logic                                    s_tlast;
    logic                                    s_tvalid;
    logic                                    s_tready;
    logic [udp_tx_pkg::UDP_WORD_BYTES*8-1:0] udp_tx_data;
    logic [udp_tx_pkg::UDP_WORD_BYTES-1:0]   udp_tx_data_valid;
    logic                                    udp_tx_sof;
    logic                                    udp_tx_eof;
    logic                                    udp_tx_cts;
    logic                                    udp_tx_ack;
    logic                                    udp_tx_nak;

    modport slave (
        input  s_tdata, s_tlast, s_tvalid,
        output s_tready,
        output udp_tx_data, udp_tx_data_valid, udp_tx_sof, udp_tx_eof,
        input  udp_tx_cts, udp_tx_ack, udp_tx_nak
    );

    modport master (
        output s_tdata, s_tlast, s_tvalid,
        input  s_tready,
        input  udp_tx_data, udp_tx_data_valid, udp_tx_sof, udp_tx_eof,
        output udp_tx_cts, udp_tx_ack, udp_tx_nak
    );

endinterface

// File: rtl/udp_tx_pkt_ram.sv
// Simple dual-port packet buffer: synchronous write, registered read with
// read enable (output holds while rd_en is low, which the framer uses to stall).
module udp_tx_pkt_ram #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_W    = 64
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [DATA_W-1:0]    rd_data
);

    logic [DATA_W-1:0] mem_r [0:(2**ADDR_BITS)-1];
    logic [DATA_W-1:0] rd_data_r;

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port, held while not enabled
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/udp_tx_framer.sv
// Store-and-forward framer: buffers one packet, sends it to the UDP client
// with SOF/EOF under CTS, waits for ACK/NAK and retransmits on NAK.
// Optional feature macro: UDP_TX_FRAMER_TIMEOUT_EN -- enables the WAIT_ACK
// timeout (implicit NAK after TIMEOUT_CYCLES); the TIMEOUT_CYCLES parameter
// only exists when the macro is defined.
module udp_tx_framer
    import udp_tx_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int MAX_RETRY = 3
`ifdef UDP_TX_FRAMER_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 4096
`endif
) (
    input  logic            clk,
    input  logic            rst,
    udp_tx_framer_if.slave  bus,
    output logic [31:0]     pkt_sent_count,
    output logic [31:0]     pkt_drop_count,
    output logic            busy
);

    localparam int                 CNT_W     = ADDR_BITS + 1;
    localparam logic [CNT_W-1:0]   LAST_SLOT = CNT_W'((2 ** ADDR_BITS) - 1);
    localparam int                 RETRY_W   = $clog2(MAX_RETRY + 2);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    udp_tx_state_t        state_r, state_nx_s;
    logic                 s_tready_r, s_tready_nx_s;
    logic                 busy_r, busy_nx_s;
    logic [CNT_W-1:0]     wcnt_r, len_r, rptr_r, rd_idx_r;
    logic                 rd_valid_r;
    logic [RETRY_W-1:0]   retry_r;
    logic [31:0]          sent_r, drop_r;
    logic [63:0]          data_r, ram_rdata_s;
    logic [7:0]           dv_r;
    logic                 sof_r, eof_r;
    logic                 in_beat_s, eof_done_s, issue_s, reject_s, retry_ok_s, tmo_hit_s;

    assign in_beat_s  = bus.s_tvalid & s_tready_r;
    assign eof_done_s = (dv_r != 8'h00) & bus.udp_tx_cts & eof_r;
    assign issue_s    = (state_r == SEND) & bus.udp_tx_cts & (rptr_r < len_r);
    assign retry_ok_s = (retry_r < RETRY_MAX);
    assign reject_s   = (state_r == WAIT_ACK) & ~bus.udp_tx_ack & (bus.udp_tx_nak | tmo_hit_s);

`ifdef UDP_TX_FRAMER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_r;

    // Cycles spent waiting for a response; cleared whenever not in WAIT_ACK
    always_ff @(posedge clk) begin
        if (rst || (state_r != WAIT_ACK)) begin
            tmo_r <= {TMO_W{1'b0}};
        end else begin
            tmo_r <= tmo_r + TMO_W'(1);
        end
    end

    assign tmo_hit_s = (state_r == WAIT_ACK) && (tmo_r == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit_s = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_beat_s) state_nx_s = bus.s_tlast ? SEND : FILL;
                else           state_nx_s = IDLE;
            end
            FILL: begin
                if (in_beat_s && bus.s_tlast)              state_nx_s = SEND;
                else if (in_beat_s && (wcnt_r == LAST_SLOT)) state_nx_s = DROP;
                else                                       state_nx_s = FILL;
            end
            DROP: begin
                if (in_beat_s && bus.s_tlast) state_nx_s = IDLE;
                else                          state_nx_s = DROP;
            end
            SEND: begin
                if (eof_done_s) state_nx_s = WAIT_ACK;
                else            state_nx_s = SEND;
            end
            WAIT_ACK: begin
                if (bus.udp_tx_ack) state_nx_s = IDLE;
                else if (reject_s)  state_nx_s = retry_ok_s ? SEND : IDLE;
                else                state_nx_s = WAIT_ACK;
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // FSM output decode, evaluated on the next state so the ports are registered
    always_comb begin
        s_tready_nx_s = 1'b1;
        busy_nx_s     = 1'b0;
        case (state_nx_s)
            IDLE:     begin s_tready_nx_s = 1'b1; busy_nx_s = 1'b0; end
            FILL:     begin s_tready_nx_s = 1'b1; busy_nx_s = 1'b1; end
            DROP:     begin s_tready_nx_s = 1'b1; busy_nx_s = 1'b1; end
            SEND:     begin s_tready_nx_s = 1'b0; busy_nx_s = 1'b1; end
            WAIT_ACK: begin s_tready_nx_s = 1'b0; busy_nx_s = 1'b1; end
            default:  begin s_tready_nx_s = 1'b1; busy_nx_s = 1'b0; end
        endcase
    end

    // Registered FSM outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            s_tready_r <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            s_tready_r <= s_tready_nx_s;
            busy_r     <= busy_nx_s;
        end
    end

    // Write pointer and packet length; len tracks the word count so far
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_r <= {CNT_W{1'b0}};
            len_r  <= {CNT_W{1'b0}};
        end else if (in_beat_s && (state_r == IDLE)) begin
            wcnt_r <= CNT_W'(1);
            len_r  <= CNT_W'(1);
        end else if (in_beat_s && (state_r == FILL)) begin
            wcnt_r <= wcnt_r + CNT_W'(1);
            len_r  <= wcnt_r + CNT_W'(1);
        end
    end

    udp_tx_pkt_ram #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_W    (64)
    ) u_ram (
        .clk     (clk),
        .wr_en   (in_beat_s & ((state_r == IDLE) | (state_r == FILL))),
        .wr_addr ((state_r == IDLE) ? {ADDR_BITS{1'b0}} : wcnt_r[ADDR_BITS-1:0]),
        .wr_data (bus.s_tdata),
        .rd_en   (issue_s),
        .rd_addr (rptr_r[ADDR_BITS-1:0]),
        .rd_data (ram_rdata_s)
    );

    // Read issue stage: whole pipeline freezes while CTS is low
    always_ff @(posedge clk) begin
        if (rst || (state_r != SEND)) begin
            rptr_r     <= {CNT_W{1'b0}};
            rd_idx_r   <= {CNT_W{1'b0}};
            rd_valid_r <= 1'b0;
        end else if (bus.udp_tx_cts) begin
            rd_valid_r <= issue_s;
            if (issue_s) begin
                rptr_r   <= rptr_r + CNT_W'(1);
                rd_idx_r <= rptr_r;
            end
        end
    end

    // Output register: holds the presented word until CTS takes it
    always_ff @(posedge clk) begin
        if (rst || (state_r != SEND)) begin
            data_r <= 64'd0;
            dv_r   <= 8'h00;
            sof_r  <= 1'b0;
            eof_r  <= 1'b0;
        end else if (bus.udp_tx_cts) begin
            if (rd_valid_r) begin
                data_r <= ram_rdata_s;
                dv_r   <= UDP_DV_FULL;
                sof_r  <= (rd_idx_r == {CNT_W{1'b0}});
                eof_r  <= (rd_idx_r == (len_r - CNT_W'(1)));
            end else begin
                data_r <= 64'd0;
                dv_r   <= 8'h00;
                sof_r  <= 1'b0;
                eof_r  <= 1'b0;
            end
        end
    end

    // Statistics counters and retry bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            sent_r  <= 32'd0;
            drop_r  <= 32'd0;
            retry_r <= {RETRY_W{1'b0}};
        end else if ((state_r == WAIT_ACK) && bus.udp_tx_ack) begin
            sent_r  <= sat_inc32(sent_r);
            retry_r <= {RETRY_W{1'b0}};
        end else if (reject_s && retry_ok_s) begin
            retry_r <= retry_r + RETRY_W'(1);
        end else if (reject_s) begin
            drop_r  <= sat_inc32(drop_r);
            retry_r <= {RETRY_W{1'b0}};
        end else if ((state_r == DROP) && in_beat_s && bus.s_tlast) begin
            drop_r  <= sat_inc32(drop_r);
        end
    end

    assign bus.s_tready          = s_tready_r;
    assign bus.udp_tx_data       = data_r;
    assign bus.udp_tx_data_valid = dv_r;
    assign bus.udp_tx_sof        = sof_r;
    assign bus.udp_tx_eof        = eof_r;
    assign pkt_sent_count        = sent_r;
    assign pkt_drop_count        = drop_r;
    assign busy                  = busy_r;

endmodule

// File: tb/tb_udp_tx_framer.sv
// Self-checking bench for udp_tx_framer: table of directed packets, a few
// hand-written sequences, then randomized packets checked against a
// packet-level reference model.
module tb_udp_tx_framer;
    import udp_tx_pkg::*;

    localparam int MAX_WORDS = 256;
    localparam int MAX_RETRY = 3;

    typedef struct {
        int          nw;
        logic [63:0] base;
        int          naks;
        int          cts_mode;
        bit          both;
        int          exp_frames;
        int          exp_sent_inc;
        int          exp_drop_inc;
    } vec_t;

    typedef struct packed {
        logic [63:0] data;
        logic        sof;
        logic        eof;
    } beat_t;

    logic        clk;
    logic        rst;
    logic [31:0] pkt_sent_count;
    logic [31:0] pkt_drop_count;
    logic        busy;

    udp_tx_framer_if bus();

    udp_tx_framer dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .pkt_sent_count (pkt_sent_count),
        .pkt_drop_count (pkt_drop_count),
        .busy           (busy)
    );

    int          checks = 0;
    int          errors = 0;
    int          eof_cnt = 0;
    int          cts_mode = 0;
    int          exp_sent = 0;
    int          exp_drop = 0;
    logic [63:0] pkt_q[$];
    beat_t       cap_q[$];
    bit          hold_pend = 1'b0;
    beat_t       hold_b;
    vec_t        vecs[10];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Packet-level reference: how many frames appear and which counter moves
    function automatic void model(input int nw, input int naks,
                                  output int frames, output int sent_inc, output int drop_inc);
        if (nw > MAX_WORDS) begin
            frames = 0; sent_inc = 0; drop_inc = 1;
        end else if (naks > MAX_RETRY) begin
            frames = MAX_RETRY + 1; sent_inc = 0; drop_inc = 1;
        end else begin
            frames = naks + 1; sent_inc = 1; drop_inc = 0;
        end
    endfunction

    // CTS pattern generator: 0 = always ready, 1 = toggle, 2 = random
    initial begin
        bus.udp_tx_cts = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (cts_mode)
                0:       bus.udp_tx_cts = 1'b1;
                1:       bus.udp_tx_cts = ~bus.udp_tx_cts;
                default: bus.udp_tx_cts = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output monitor: capture beats, check stability of stalled words
    always @(negedge clk) begin
        beat_t cur;
        cur = '{bus.udp_tx_data, bus.udp_tx_sof, bus.udp_tx_eof};
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_dv", 64'(bus.udp_tx_data_valid), 64'hFF);
                check("hold_word", cur.data, hold_b.data);
                check("hold_flags", 64'({cur.sof, cur.eof}), 64'({hold_b.sof, hold_b.eof}));
            end
            if (bus.udp_tx_data_valid != 8'h00) begin
                check("dv_full", 64'(bus.udp_tx_data_valid), 64'hFF);
                if (bus.udp_tx_cts) begin
                    cap_q.push_back(cur);
                    if (cur.eof) eof_cnt++;
                    hold_pend = 1'b0;
                end else begin
                    hold_pend = 1'b1;
                    hold_b    = cur;
                end
            end else begin
                hold_pend = 1'b0;
            end
        end
    end

    task automatic drive_pkt(input string tag);
        int i = 0;
        int guard = 0;
        bit took;
        while (i < pkt_q.size() && guard < 4000) begin
            bus.s_tvalid = ($urandom_range(0, 3) != 0);
            bus.s_tdata  = pkt_q[i];
            bus.s_tlast  = (i == pkt_q.size() - 1);
            took = bus.s_tvalid && bus.s_tready;
            @(posedge clk);
            #1;
            if (took) i++;
            guard++;
        end
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
        check({tag, "_accepted"}, 64'(i), 64'(pkt_q.size()));
    endtask

    task automatic wait_eof(input string tag, input int n, output bit ok);
        int k = 0;
        while (eof_cnt < n && k < 6000) begin
            @(posedge clk);
            #1;
            k++;
        end
        ok = (eof_cnt >= n);
        check({tag, "_eof_seen"}, 64'(eof_cnt >= n), 64'd1);
    endtask

    task automatic load_pkt(input int nw, input logic [63:0] base);
        pkt_q.delete();
        for (int i = 0; i < nw; i++) pkt_q.push_back(base + 64'(i));
        cap_q.delete();
        eof_cnt = 0;
    endtask

    task automatic run_pkt(input string tag, input int nw, input logic [63:0] base,
                           input int naks, input int mode, input bit both,
                           input int exp_frames, input int sent_inc, input int drop_inc);
        bit ok;
        int tot;
        int k;
        load_pkt(nw, base);
        cts_mode = mode;
        drive_pkt(tag);
        for (int r = 0; r < exp_frames; r++) begin
            wait_eof(tag, r + 1, ok);
            if (!ok) break;
            repeat (3) @(posedge clk);
            #1;
            if (r < naks) begin
                bus.udp_tx_nak = 1'b1;
            end else begin
                bus.udp_tx_ack = 1'b1;
                bus.udp_tx_nak = both;
            end
            @(posedge clk);
            #1;
            bus.udp_tx_ack = 1'b0;
            bus.udp_tx_nak = 1'b0;
        end
        exp_sent += sent_inc;
        exp_drop += drop_inc;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check({tag, "_beats"}, 64'(cap_q.size()), 64'(exp_frames * nw));
        check({tag, "_frames"}, 64'(eof_cnt), 64'(exp_frames));
        tot = cap_q.size();
        if (tot > exp_frames * nw) tot = exp_frames * nw;
        for (int j = 0; j < tot; j++) begin
            k = j % nw;
            check({tag, "_data"}, cap_q[j].data, base + 64'(k));
            check({tag, "_sof"}, 64'(cap_q[j].sof), 64'(k == 0));
            check({tag, "_eof"}, 64'(cap_q[j].eof), 64'(k == nw - 1));
        end
        check({tag, "_sent"}, 64'(pkt_sent_count), 64'(exp_sent));
        check({tag, "_drop"}, 64'(pkt_drop_count), 64'(exp_drop));
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_tready"}, 64'(bus.s_tready), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit ok;
        int nw, naks, fr, si, di, k;

        vecs[0] = '{4,   64'd1,            0, 0, 1'b0, 1, 1, 0};
        vecs[1] = '{1,   64'hDEAD_BEEF,    0, 0, 1'b0, 1, 1, 0};
        vecs[2] = '{8,   64'd1,            0, 1, 1'b0, 1, 1, 0};
        vecs[3] = '{5,   64'h100,          3, 0, 1'b0, 4, 1, 0};
        vecs[4] = '{5,   64'h200,          4, 2, 1'b0, 4, 0, 1};
        vecs[5] = '{300, 64'h300,          0, 0, 1'b0, 0, 0, 1};
        vecs[6] = '{2,   64'h400,          0, 0, 1'b0, 1, 1, 0};
        vecs[7] = '{256, 64'h1000,         0, 2, 1'b0, 1, 1, 0};
        vecs[8] = '{257, 64'h2000,         0, 0, 1'b0, 0, 0, 1};
        vecs[9] = '{3,   64'h500,          0, 2, 1'b1, 1, 1, 0};

        rst = 1'b1;
        bus.s_tvalid   = 1'b0;
        bus.s_tlast    = 1'b0;
        bus.s_tdata    = 64'd0;
        bus.udp_tx_ack = 1'b0;
        bus.udp_tx_nak = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_dv", 64'(bus.udp_tx_data_valid), 64'd0);
        check("rst_data", bus.udp_tx_data, 64'd0);
        check("rst_sofeof", 64'({bus.udp_tx_sof, bus.udp_tx_eof}), 64'd0);
        check("rst_tready", 64'(bus.s_tready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sent", 64'(pkt_sent_count), 64'd0);
        check("rst_drop", 64'(pkt_drop_count), 64'd0);
        @(posedge clk);
        #1;

        // Directed table
        for (int v = 0; v < 10; v++) begin
            run_pkt($sformatf("vec%0d", v), vecs[v].nw, vecs[v].base, vecs[v].naks,
                    vecs[v].cts_mode, vecs[v].both, vecs[v].exp_frames,
                    vecs[v].exp_sent_inc, vecs[v].exp_drop_inc);
        end

        // Responses while idle must be ignored
        cap_q.delete();
        eof_cnt = 0;
        bus.udp_tx_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.udp_tx_ack = 1'b0;
        bus.udp_tx_nak = 1'b1;
        @(posedge clk);
        #1;
        bus.udp_tx_nak = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("idle_ack_sent", 64'(pkt_sent_count), 64'(exp_sent));
        check("idle_ack_drop", 64'(pkt_drop_count), 64'(exp_drop));
        check("idle_ack_busy", 64'(busy), 64'd0);
        check("idle_ack_beats", 64'(cap_q.size()), 64'd0);
        @(posedge clk);
        #1;

`ifdef UDP_TX_FRAMER_TIMEOUT_EN
        // No response at all: original + 3 timed-out retransmissions, then drop
        load_pkt(3, 64'h700);
        cts_mode = 0;
        drive_pkt("tmo");
        k = 0;
        while (busy && k < 6 * 4096 + 2000) begin
            @(posedge clk);
            #1;
            k++;
        end
        exp_drop++;
        @(negedge clk);
        check("tmo_idle", 64'(busy), 64'd0);
        check("tmo_frames", 64'(eof_cnt), 64'd4);
        check("tmo_beats", 64'(cap_q.size()), 64'd12);
        check("tmo_drop", 64'(pkt_drop_count), 64'(exp_drop));
        check("tmo_sent", 64'(pkt_sent_count), 64'(exp_sent));
        @(posedge clk);
        #1;
`else
        // No response: the framer keeps waiting and never retransmits
        load_pkt(3, 64'h700);
        cts_mode = 0;
        drive_pkt("wait");
        wait_eof("wait", 1, ok);
        repeat (300) @(posedge clk);
        @(negedge clk);
        check("wait_busy", 64'(busy), 64'd1);
        check("wait_frames", 64'(eof_cnt), 64'd1);
        check("wait_tready", 64'(bus.s_tready), 64'd0);
        @(posedge clk);
        #1;
        bus.udp_tx_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.udp_tx_ack = 1'b0;
        exp_sent++;
        @(negedge clk);
        check("wait_ack_sent", 64'(pkt_sent_count), 64'(exp_sent));
        check("wait_ack_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
`endif

        // Randomized packets against the reference model
        for (int t = 0; t < 12; t++) begin
            nw   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(250, 262))
                                              : int'($urandom_range(1, 16));
            naks = int'($urandom_range(0, 5));
            model(nw, naks, fr, si, di);
            run_pkt($sformatf("rnd%0d", t), nw, {$urandom, $urandom}, naks, 2, 1'b0, fr, si, di);
        end

        // Reset in the middle of a frame
        load_pkt(6, 64'h900);
        cts_mode = 0;
        drive_pkt("midrst");
        k = 0;
        while (cap_q.size() < 2 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("midrst_started", 64'(cap_q.size() >= 2), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_dv", 64'(bus.udp_tx_data_valid), 64'd0);
        check("midrst_sofeof", 64'({bus.udp_tx_sof, bus.udp_tx_eof}), 64'd0);
        check("midrst_sent", 64'(pkt_sent_count), 64'd0);
        check("midrst_drop", 64'(pkt_drop_count), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_tready", 64'(bus.s_tready), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_sent = 0;
        exp_drop = 0;
        cap_q.delete();
        eof_cnt = 0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("midrst_no_eof", 64'(eof_cnt), 64'd0);
        check("midrst_no_beats", 64'(cap_q.size()), 64'd0);
        @(posedge clk);
        #1;

        // Normal traffic resumes after the reset
        run_pkt("post_rst", 2, 64'hA00, 0, 0, 1'b0, 1, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
